// File: rtl/trace_pkg.sv
// Shared definitions for the register/memory write trace unit: source codes,
// the default-width entry layout and the entry-width helper.
package trace_pkg;

    localparam logic SRC_RF = 1'b0;
    localparam logic SRC_DM = 1'b1;

    localparam int TRACE_XLEN   = 32;
    localparam int TRACE_ADDR_W = 8;
    localparam int TRACE_CYC_W  = 16;

    // Layout at default widths; other widths use the same field order.
    typedef struct packed {
        logic                    src;
        logic [TRACE_CYC_W-1:0]  cycle;
        logic [TRACE_ADDR_W-1:0] addr;
        logic [TRACE_XLEN-1:0]   data;
    } trace_entry_t;

    function automatic int entry_width(input int xlen, input int addr_w, input int cyc_w);
        return 1 + cyc_w + addr_w + xlen;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead circular buffer accepting up to two pushes and one pop per cycle.
// The caller guarantees pushes never exceed free space; push_b implies push_a.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int WIDTH = entry_width(TRACE_XLEN, TRACE_ADDR_W, TRACE_CYC_W),
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             push_b,
    input  logic [WIDTH-1:0] data_b,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_b;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] n_push;
    logic             do_pop;

    assign wr_ptr_b = wr_ptr_q + PTR_W'(1);
    assign do_pop   = pop && (count_q != '0);

    always_comb begin
        n_push   = CNT_W'(push_a) + CNT_W'(push_a && push_b);
        wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + n_push - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: stale contents are masked by count.
    always_ff @(posedge clk) begin
        if (push_a) mem_q[wr_ptr_q] <= data_a;
        if (push_a && push_b) mem_q[wr_ptr_b] <= data_b;
    end

    assign rd_data = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/reg_trace_buffer.sv
// Trace unit: timestamps RF and DM writes into a drainable FIFO, halts after a cycle budget.
// Build option TRACE_FILTER_X0_EN: ignore register writes to x0.
module reg_trace_buffer
    import trace_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 16,
    parameter int CYC_W      = 16,
    parameter int MAX_CYCLES = 12,
    parameter int OVF_W      = 8,
    localparam int ENTRY_W   = entry_width(XLEN, ADDR_W, CYC_W),
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rf_we,
    input  logic [4:0]         rf_waddr,
    input  logic [XLEN-1:0]    rf_wdata,
    input  logic               dm_we,
    input  logic [XLEN-1:0]    dm_addr,
    input  logic [XLEN-1:0]    dm_wdata,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [ENTRY_W-1:0] rd_data,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               halted,
    output logic [CYC_W-1:0]   cycle,
    output logic [OVF_W-1:0]   ovf_cnt
);

    localparam int SP_W = CNT_W + 1;

    logic [CYC_W-1:0]   cycle_q, cycle_d;
    logic               halted_q, halted_d;
    logic [OVF_W-1:0]   ovf_q, ovf_d;
    logic [OVF_W:0]     ovf_sum;
    logic               ev_rf, ev_dm, pop;
    logic [SP_W-1:0]    space;
    logic [1:0]         n_drop;
    logic               push_a, push_b;
    logic [ENTRY_W-1:0] entry_rf, entry_dm, data_a;
    logic               unused_dm_addr;

    assign unused_dm_addr = ^dm_addr;

`ifdef TRACE_FILTER_X0_EN
    assign ev_rf = rf_we && !halted_q && (rf_waddr != 5'd0);
`else
    assign ev_rf = rf_we && !halted_q;
`endif
    assign ev_dm = dm_we && !halted_q;

    assign entry_rf = {SRC_RF, cycle_q, ADDR_W'(rf_waddr), rf_wdata};
    assign entry_dm = {SRC_DM, cycle_q, dm_addr[ADDR_W-1:0], dm_wdata};

    assign pop   = rd_valid && rd_ready;
    assign space = SP_W'(DEPTH) - {1'b0, count} + SP_W'(pop);

    // RF always takes the first slot so a shortfall of one drops the DM event.
    always_comb begin
        push_a = 1'b0;
        push_b = 1'b0;
        data_a = entry_rf;
        n_drop = 2'd0;
        if (ev_rf && ev_dm) begin
            if (space >= SP_W'(2)) begin
                push_a = 1'b1;
                push_b = 1'b1;
            end else if (space == SP_W'(1)) begin
                push_a = 1'b1;
                n_drop = 2'd1;
            end else begin
                n_drop = 2'd2;
            end
        end else if (ev_rf || ev_dm) begin
            data_a = ev_rf ? entry_rf : entry_dm;
            if (space != '0) push_a = 1'b1;
            else             n_drop = 2'd1;
        end
    end

    always_comb begin
        cycle_d  = cycle_q;
        halted_d = halted_q;
        if (!halted_q) begin
            cycle_d = cycle_q + CYC_W'(1);
            if (MAX_CYCLES != 0 && cycle_q == CYC_W'(MAX_CYCLES - 1)) halted_d = 1'b1;
        end
        ovf_sum = {1'b0, ovf_q} + (OVF_W + 1)'(n_drop);
        ovf_d   = ovf_sum[OVF_W] ? '1 : ovf_sum[OVF_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q  <= '0;
            halted_q <= 1'b0;
            ovf_q    <= '0;
        end else begin
            cycle_q  <= cycle_d;
            halted_q <= halted_d;
            ovf_q    <= ovf_d;
        end
    end

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_a  (push_a),
        .data_a  (data_a),
        .push_b  (push_b),
        .data_b  (entry_dm),
        .pop     (pop),
        .rd_data (rd_data),
        .count   (count)
    );

    assign rd_valid = (count != '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign halted   = halted_q;
    assign cycle    = cycle_q;
    assign ovf_cnt  = ovf_q;

endmodule

// File: tb/tb_reg_trace_buffer.sv
// Bench for reg_trace_buffer: instance A keeps the 12-cycle budget, instance B never
// halts and is checked against a queue scoreboard of expected entries.
module tb_reg_trace_buffer;
    import trace_pkg::*;

    localparam int ENTRY_W = entry_width(32, 8, 16);
    localparam int DEPTH   = 16;
`ifdef TRACE_FILTER_X0_EN
    localparam bit FILT_X0 = 1'b1;
`else
    localparam bit FILT_X0 = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b0, rst_b = 1'b0;
    logic        rf_we = 1'b0, dm_we = 1'b0;
    logic [4:0]  rf_waddr = '0;
    logic [31:0] rf_wdata = '0, dm_addr = '0, dm_wdata = '0;
    logic        rd_ready_a = 1'b0, rd_ready_b = 1'b0;

    logic               rd_valid_a, rd_valid_b, full_a, full_b, halted_a, halted_b;
    logic [ENTRY_W-1:0] rd_data_a, rd_data_b;
    logic [4:0]         count_a, count_b;
    logic [15:0]        cycle_a, cycle_b;
    logic [7:0]         ovf_a, ovf_b;

    reg_trace_buffer u_dut_a (
        .clk(clk), .rst(rst_a), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .rd_valid(rd_valid_a),
        .rd_ready(rd_ready_a), .rd_data(rd_data_a), .count(count_a), .full(full_a),
        .halted(halted_a), .cycle(cycle_a), .ovf_cnt(ovf_a)
    );

    reg_trace_buffer #(.MAX_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rst_b), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .rd_valid(rd_valid_b),
        .rd_ready(rd_ready_b), .rd_data(rd_data_b), .count(count_b), .full(full_b),
        .halted(halted_b), .cycle(cycle_b), .ovf_cnt(ovf_b)
    );

    int checks = 0;
    int failures = 0;
    logic [ENTRY_W-1:0] exp_q [$];
    int exp_ovf = 0;
    int cyc_b = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ENTRY_W-1:0] mk(input logic src, input int cyc,
                                              input logic [7:0] addr, input logic [31:0] data);
        trace_entry_t e;
        e.src   = src;
        e.cycle = cyc[15:0];
        e.addr  = addr;
        e.data  = data;
        return e;
    endfunction

    // One clock: drive, check B's head, update the scoreboard, then check B's state.
    task automatic cyc(input logic rfw, input logic [4:0] ra, input logic [31:0] rdat,
                       input logic dmw, input logic [31:0] da, input logic [31:0] dd,
                       input logic rdy);
        int space;
        int drops;
        bit popped;
        rf_we = rfw; rf_waddr = ra; rf_wdata = rdat;
        dm_we = dmw; dm_addr = da; dm_wdata = dd;
        rd_ready_b = rdy;
        #1;
        if (exp_q.size() != 0) check("b_head", rd_data_b, exp_q[0]);
        else                   check("b_empty_data", rd_data_b, 0);
        popped = (exp_q.size() != 0) && rdy;
        space  = DEPTH - exp_q.size() + int'(popped);
        if (popped) void'(exp_q.pop_front());
        drops = 0;
        if (rfw && !(FILT_X0 && ra == 5'd0)) begin
            if (space > 0) begin exp_q.push_back(mk(SRC_RF, cyc_b, {3'b0, ra}, rdat)); space--; end
            else drops++;
        end
        if (dmw) begin
            if (space > 0) begin exp_q.push_back(mk(SRC_DM, cyc_b, da[7:0], dd)); space--; end
            else drops++;
        end
        @(posedge clk);
        #1;
        rf_we = 1'b0; dm_we = 1'b0; rd_ready_b = 1'b0;
        cyc_b++;
        exp_ovf = (exp_ovf + drops > 255) ? 255 : exp_ovf + drops;
        check("b_count", count_b, exp_q.size());
        check("b_full", full_b, exp_q.size() == DEPTH);
        check("b_valid", rd_valid_b, exp_q.size() != 0);
        check("b_ovf", ovf_b, exp_ovf);
        check("b_cycle", cycle_b, cyc_b);
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, rdy);
    endtask

    initial begin
        // Reset both instances.
        rst_a = 1'b1; rst_b = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;
        check("a_rst_cycle", cycle_a, 0);
        check("a_rst_halted", halted_a, 0);
        check("a_rst_count", count_a, 0);
        check("a_rst_full", full_a, 0);
        check("a_rst_valid", rd_valid_a, 0);
        check("a_rst_data", rd_data_a, 0);
        check("a_rst_ovf", ovf_a, 0);
        check("b_rst_count", count_b, 0);

        // First write lands at cycle 3.
        repeat (3) idle(1'b0);
        cyc(1'b1, 5'd4, 32'h2A, 1'b0, 32'd0, 32'd0, 1'b0);
        check("a_t1_valid", rd_valid_a, 1);
        check("a_t1_count", count_a, 1);
        check("a_t1_data", rd_data_a, mk(1'b0, 3, 8'h04, 32'h2A));

        // Dual event at cycle 4: RF then DM.
        cyc(1'b1, 5'd1, 32'd5, 1'b1, 32'h10, 32'd9, 1'b0);
        check("a_dual_count", count_a, 3);

        // Run A to its budget.
        while (cyc_b < 11) idle(1'b0);
        check("a_prehalt", halted_a, 0);
        check("a_prehalt_cycle", cycle_a, 11);
        idle(1'b0);
        check("a_halted", halted_a, 1);
        check("a_halt_cycle", cycle_a, 12);
        cyc(1'b1, 5'd2, 32'h77, 1'b0, 32'd0, 32'd0, 1'b0);
        check("a_halt_nocap", count_a, 3);
        check("a_halt_hold", cycle_a, 12);

        // Drain A while halted.
        rd_ready_a = 1'b1;
        @(posedge clk); #1;
        rd_ready_a = 1'b0;
        check("a_drain_count", count_a, 2);
        check("a_drain_head", rd_data_a, mk(1'b0, 4, 8'h01, 32'd5));
        cyc_b++;

        // Drain B completely: head checks cover RF-before-DM order.
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1'b1);
        check("b_drained", count_b, 0);

        // Fill to DEPTH-1, then overflow with dual events.
        for (int i = 0; i < DEPTH - 1; i++) cyc(1'b1, 5'(i + 1), 32'h100 + i, 1'b0, 32'd0, 32'd0, 1'b0);
        check("b_fill15", count_b, 15);
        cyc(1'b1, 5'd7, 32'hAA, 1'b1, 32'h1234, 32'hBB, 1'b0);
        check("b_ovf1_full", full_b, 1);
        check("b_ovf1", ovf_b, 1);
        cyc(1'b1, 5'd8, 32'hCC, 1'b1, 32'h55, 32'hDD, 1'b0);
        check("b_ovf3", ovf_b, 3);

        // Saturation of the drop counter.
        for (int i = 0; i < 130; i++) cyc(1'b1, 5'd9, 32'(i), 1'b1, 32'h66, 32'(i), 1'b0);
        check("b_ovf_sat", ovf_b, 255);

        // Push and pop at full.
        cyc(1'b1, 5'd3, 32'hEE, 1'b0, 32'd0, 32'd0, 1'b1);
        check("b_fullpp_count", count_b, 16);
        check("b_fullpp_ovf", ovf_b, 255);

        // Drain to 7 then reset mid-drain with traffic present.
        repeat (9) idle(1'b1);
        check("b_mid_count", count_b, 7);
        rst_b = 1'b1; rd_ready_b = 1'b1; rf_we = 1'b1; dm_we = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0; rd_ready_b = 1'b0; rf_we = 1'b0; dm_we = 1'b0;
        exp_q.delete(); exp_ovf = 0; cyc_b = 0;
        check("b_rst_count2", count_b, 0);
        check("b_rst_valid2", rd_valid_b, 0);
        check("b_rst_cycle2", cycle_b, 0);
        check("b_rst_halted2", halted_b, 0);
        check("b_rst_ovf2", ovf_b, 0);
        check("b_rst_data2", rd_data_b, 0);

        // x0 write: filtered only when the build option is on.
        cyc(1'b1, 5'd0, 32'h99, 1'b0, 32'd0, 32'd0, 1'b0);
        check("b_x0_count", count_b, FILT_X0 ? 0 : 1);
        check("b_x0_ovf", ovf_b, 0);
        idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_trace_buffer.md
Name: reg_trace_buffer

Overview:
- Parametrised hardware trace unit for the single-cycle and pipelined RISC-V cores.
- Snoops the register-file write port and the data-memory write port, and timestamps each write with a cycle counter.
- Stores events in a show-ahead FIFO that is drained through a valid/ready handshake.
- Raises a sticky halt after a programmable cycle budget, so run-N-cycles-and-stop moves from the testbench into RTL.

Parameters:
- XLEN, 32, data width of captured write values.
- ADDR_W, 8, address field width; register index zero-extended, memory address truncated to low ADDR_W bits.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- CYC_W, 16, cycle counter and timestamp width.
- MAX_CYCLES, 12, cycle budget before halt; 0 means never halt.
- OVF_W, 8, overflow counter width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- rf_we  in  1  register-file write enable.
- rf_waddr  in  5  register index.
- rf_wdata  in  XLEN  register write value.
- dm_we  in  1  data-memory write enable.
- dm_addr  in  XLEN  memory write address.
- dm_wdata  in  XLEN  memory write value.
- rd_valid  out  1  head entry available.
- rd_ready  in  1  consumer accepts head.
- rd_data  out  1+CYC_W+ADDR_W+XLEN  entry packed as {src, cycle, addr, data}; src is 0 for RF, 1 for DM.
- count  out  clog2(DEPTH)+1  occupied entries.
- full  out  1  count == DEPTH.
- halted  out  1  sticky cycle-budget-reached flag.
- cycle  out  CYC_W  current cycle counter.
- ovf_cnt  out  OVF_W  dropped-event counter, saturating.

Behaviour:
- Reset, clk and rst exactly as above (synchronous, active-high). Reset has priority over every other action, including mid-burst.
  - Reset values: cycle=0, halted=0, count=0, full=0, ovf_cnt=0, rd_valid=0, rd_data=0, read and write pointers = 0.
  - Entries pending at reset are discarded.
- Cycle counter:
  - Increments by 1 each posedge while !halted.
  - When MAX_CYCLES != 0 and cycle == MAX_CYCLES-1, the same edge sets cycle=MAX_CYCLES and halted=1.
  - After halt, cycle holds its value.
  - With MAX_CYCLES=0, cycle wraps modulo 2^CYC_W and never halts.
- Capture:
  - On a posedge with !halted, each asserted we produces one entry, stamped with the pre-edge cycle value.
  - Nothing is captured while halted.
  - Draining continues while halted.
- Ordering: if rf_we and dm_we are asserted in the same cycle, the RF entry is written first and the DM entry directly after (two pushes in one cycle).
- Free space: space = DEPTH - count + pop, where pop = rd_valid && rd_ready.
  - Simultaneous push and pop at full is legal.
- Drops:
  - If 2 events arrive and space is 1, the RF event is stored, the DM event is dropped, and ovf_cnt += 1.
  - If space is 0, every event is dropped and ovf_cnt += number dropped.
  - ovf_cnt saturates at 2^OVF_W-1.
- Read side (show-ahead):
  - rd_valid = (count != 0).
  - rd_data = head entry combinationally; forced to 0 when count == 0.
  - Pop occurs on a posedge when rd_valid && rd_ready.
  - rd_ready while empty has no effect.
- Pointers and count:
  - Pointers wrap modulo DEPTH.
  - count is updated as count + pushes - pop.
  - full = (count == DEPTH).

Optional Feature:
- Macro: TRACE_FILTER_X0_EN.
- Defined: rf_we with rf_waddr == 0 is ignored. Such a write creates no entry, consumes no space and never counts as a drop.
- Undefined: x0 writes are traced like any other register.

Decomposition:
- Shared package trace_pkg holds:
  - SRC_RF=0 and SRC_DM=1 constants.
  - Packed entry typedef trace_entry_t with fields src, cycle, addr and data.
  - Entry-width helper function.
- One natural sub-module, trace_fifo: a 2-push/1-pop show-ahead circular buffer with count.
- Capture, arbitration, cycle/halt logic and overflow counting stay in the top module.

Test Plan:
1. Reset, then rf_we at cycle 3 (rf_waddr=4, rf_wdata=0x2A) with rd_ready=0 -> rd_valid=1, count=1, rd_data={0, 3, 0x04, 0x2A}.
2. MAX_CYCLES=12, run free -> halted rises at the edge where cycle becomes 12. A later rf_we creates no entry; cycle stays 12.
3. Same cycle rf_we (x1=5) and dm_we (addr=0x10, data=9) -> two entries, RF first. Pops return src 0, then src 1, both with the same timestamp.
4. Fill to DEPTH-1=15 with no reads, then send a dual event -> RF entry stored, count=16, full=1, ovf_cnt=1. Another dual event gives ovf_cnt=3.
5. At full, rf_we with rd_ready=1 -> one pop and one push; count stays 16 and ovf_cnt is unchanged.
6. Assert rst mid-drain with count=7 -> next edge gives count=0, rd_valid=0, cycle=0, halted=0, ovf_cnt=0. Repeat the x0 write with TRACE_FILTER_X0_EN defined and undefined: 0 entries when defined, 1 when undefined.
